uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  8N1 UART transmitter with an internal baud counter and a small TX FIFO.
//  Return path of the UART link: the watch/stopwatch logic in uart_top pushes
//  ASCII bytes (status, echo of 'r'/'u' commands) and this block serialises them
//  onto uart_tx. Frames are LSB first.
// PARAMETERS
//  CLK_FREQ    100_000_000  system clock in Hz
//  BAUD        9600         line rate; BIT_CLKS = CLK_FREQ/BAUD (integer div) = 10416
//  FIFO_DEPTH  4            TX FIFO entries; power of two, >= 2
// PORTS
//  clk       in   1  system clock, all logic on rising edge
//  rst       in   1  synchronous, active-low reset (0 = reset)
//  tx_data   in   8  byte to send
//  tx_push   in   1  write tx_data into FIFO this cycle
//  tx_full   out  1  FIFO holds FIFO_DEPTH entries; pushes ignored
//  tx_empty  out  1  FIFO holds 0 entries
//  tx_busy   out  1  frame in progress (state != IDLE)
//  uart_tx   out  1  serial line, idle high, registered output
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): uart_tx=1, state=IDLE, FIFO count/pointers=0,
//   baud/bit counters=0, tx_full=0, tx_empty=1, tx_busy=0. Applies mid-frame:
//   frame is aborted, line is high on the next edge, queued bytes are discarded.
//  FIFO: circular buffer, wr/rd pointers wrap modulo FIFO_DEPTH, count 0..DEPTH.
//   - Push when tx_full=1: byte dropped, no state change.
//   - Push and pop on the same edge (not full): count unchanged, both pointers advance.
//   - tx_full/tx_empty are decoded from the registered count (no extra latency).
//  FSM states IDLE, START, DATA, STOP. baud_cnt counts 0..BIT_CLKS-1;
//   bit_end = (baud_cnt == BIT_CLKS-1). bit_idx 0..7.
//   IDLE : uart_tx=1. If FIFO non-empty: pop head into shift reg, baud_cnt=0,
//          uart_tx<=0, go START (same edge).
//   START: hold 0; on bit_end: uart_tx<=shift[0], bit_idx=0, go DATA.
//   DATA : on bit_end: if bit_idx==7, uart_tx<=1, go STOP; else shift right,
//          uart_tx<=next bit, bit_idx++.
//   STOP : hold 1; on bit_end: if FIFO non-empty, pop, uart_tx<=0, go START
//          (back-to-back, no idle gap); else go IDLE.
//  Every bit (start, 8 data, stop) lasts exactly BIT_CLKS clocks; frame = 10*BIT_CLKS.
//  Latency: byte pushed at edge N into empty FIFO while IDLE -> popped at edge N+1,
//   uart_tx low from edge N+1. A push at edge N is not visible to the pop at edge N.
//  tx_busy=1 in START/DATA/STOP; tx_data is not sampled except on an accepted push.
//  Bytes leave in push order; none is duplicated or reordered.
// TESTING
//  1 Reset held 10 us then released, no push -> uart_tx stays 1, tx_empty=1, tx_busy=0.
//  2 Push 0x72 ('r') once -> uart_tx low 1 clk later; line reads 0,0,1,0,0,1,1,1,0,1
//    (start, LSB..MSB, stop), each for 10416 clks; tx_busy drops after 104160 clks.
//  3 Push 0x72,0x72,0x75 on consecutive clks -> three contiguous frames, no high gap
//    between stop and next start; total 312480 clks busy; decoded 'r','r','u'.
//  4 Push 0x01..0x06 on six consecutive clks while IDLE -> tx_full=1 after 5th push,
//    0x06 dropped; exactly 0x01..0x05 transmitted in order.
//  5 rst=0 for 1 clk in DATA of frame 0x55 with 2 bytes queued -> uart_tx=1 next edge,
//    tx_empty=1, tx_busy=0; no further frames without new pushes.
//  6 Push on the same edge as STOP->START pop with FIFO 3/4 full -> count stays 3,
//    tx_full never asserts, byte order preserved.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter, LSB first, fed by a small circular TX FIFO.
// The baud counter runs only while a frame is on the line. The stop bit can pop
// the next byte so that queued frames go out back to back.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_push,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       uart_tx
);

  localparam int BIT_CLKS = CLK_FREQ / BAUD;
  localparam int CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] BAUD_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
  localparam logic [PW:0]   CNT_ZERO  = {(PW+1){1'b0}};
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1'b1);
  localparam logic [PW:0]   CNT_FULL  = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;

  state_t        state_r;
  logic [CW-1:0] baud_cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          uart_tx_r;

  logic          bit_end_s;
  logic          push_s;
  logic          pop_s;

  assign bit_end_s = (baud_cnt_r == BIT_LAST);
  assign tx_full   = (count_r == CNT_FULL);
  assign tx_empty  = (count_r == CNT_ZERO);
  assign tx_busy   = (state_r != IDLE);
  assign uart_tx   = uart_tx_r;
  assign push_s    = tx_push & ~tx_full;

  // Pop the FIFO head when idle, or at the end of a stop bit to chain frames.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      IDLE:    pop_s = ~tx_empty;
      STOP:    pop_s = bit_end_s & ~tx_empty;
      default: pop_s = 1'b0;
    endcase
  end

  // FIFO storage: data only, no reset needed since count guards every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; pointer wrap relies on power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame FSM: drives the registered line and times every bit with baud_cnt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      baud_cnt_r <= BAUD_ZERO;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      uart_tx_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          uart_tx_r  <= 1'b1;
          baud_cnt_r <= BAUD_ZERO;
          if (pop_s) begin
            shift_r   <= mem_r[rd_ptr_r];
            uart_tx_r <= 1'b0;
            state_r   <= START;
          end
        end
        START: begin
          if (bit_end_s) begin
            baud_cnt_r <= BAUD_ZERO;
            uart_tx_r  <= shift_r[0];
            bit_idx_r  <= 3'd0;
            state_r    <= DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= BAUD_ZERO;
            if (bit_idx_r == 3'd7) begin
              uart_tx_r <= 1'b1;
              state_r   <= STOP;
            end else begin
              shift_r   <= {1'b0, shift_r[7:1]};
              uart_tx_r <= shift_r[1];
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            baud_cnt_r <= BAUD_ZERO;
            if (pop_s) begin
              shift_r   <= mem_r[rd_ptr_r];
              uart_tx_r <= 1'b0;
              state_r   <= START;
            end else begin
              uart_tx_r <= 1'b1;
              state_r   <= IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= BAUD_ZERO;
          uart_tx_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench. Pushed bytes are queued as expectations;
// a line decoder samples each bit mid-cell and compares decoded frames in order.
// The baud divider is shrunk to 10 clocks per bit to keep runs short.
module tb_uart_tx_fifo;

  localparam int B = 10;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_push;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_busy;
  logic       uart_tx;

  int n_tests;
  int n_fail;

  logic [7:0] exp_q[$];

  logic       mon_clear;
  logic       mon_active;
  int         mon_cnt;
  logic [7:0] mon_byte;

  logic busy_clr;
  int   busy_cnt;
  logic full_clr;
  logic full_seen;

  uart_tx_fifo #(
    .CLK_FREQ  (1000),
    .BAUD      (100),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_push (tx_push),
    .tx_full (tx_full),
    .tx_empty(tx_empty),
    .tx_busy (tx_busy),
    .uart_tx (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Push one byte on the next rising edge; returns 1 time unit after that edge.
  task automatic push_byte(input logic [7:0] d);
    tx_data = d;
    tx_push = 1'b1;
    @(posedge clk);
    #1;
    tx_push = 1'b0;
  endtask

  // Advance at least one edge, then until the transmitter is idle or the limit expires.
  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (tx_busy && n < limit);
    chk("idle_timeout", {31'd0, tx_busy}, 32'd0);
  endtask

  // Line decoder: start detect, mid-bit sampling, frame check against the scoreboard.
  always @(negedge clk) begin
    if (mon_clear) begin
      mon_active <= 1'b0;
      mon_cnt    <= 0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active <= 1'b1;
        mon_cnt    <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt == B / 2) begin
        chk("start_bit", {31'd0, uart_tx}, 32'd0);
      end else if (mon_cnt == 9 * B + B / 2) begin
        chk("stop_bit", {31'd0, uart_tx}, 32'd1);
        if (exp_q.size() == 0) begin
          chk("sb_underflow", exp_q.size(), 32'd1);
        end else begin
          chk("frame_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
        end
        mon_active <= 1'b0;
      end else if ((mon_cnt % B) == B / 2 && (mon_cnt / B) >= 1 && (mon_cnt / B) <= 8) begin
        mon_byte[(mon_cnt / B) - 1] <= uart_tx;
      end
    end
  end

  // Busy-cycle counter and sticky full flag, both clearable from the stimulus.
  always @(negedge clk) begin
    if (busy_clr) begin
      busy_cnt <= 0;
    end else if (tx_busy === 1'b1) begin
      busy_cnt <= busy_cnt + 1;
    end
    if (full_clr) begin
      full_seen <= 1'b0;
    end else if (tx_full === 1'b1) begin
      full_seen <= 1'b1;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    tx_data   = 8'h00;
    tx_push   = 1'b0;
    mon_clear = 1'b1;
    busy_clr  = 1'b1;
    full_clr  = 1'b1;

    // 1: reset held 10 us, then idle with no pushes
    repeat (1000) @(posedge clk);
    #1;
    chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_empty", {31'd0, tx_empty}, 32'd1);
    chk("rst_full", {31'd0, tx_full}, 32'd0);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    rst       = 1'b1;
    mon_clear = 1'b0;
    busy_clr  = 1'b0;
    full_clr  = 1'b0;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (uart_tx === 1'b1) highs++;
    end
    chk("idle_line_high", highs, 32'd20);
    chk("idle_busy", {31'd0, tx_busy}, 32'd0);

    // 2: single byte 'r', latency and frame length
    busy_clr = 1'b1;
    @(posedge clk);
    #1;
    busy_clr = 1'b0;
    exp_q.push_back(8'h72);
    push_byte(8'h72);
    chk("lat_no_pop_yet", {31'd0, tx_empty}, 32'd0);
    chk("lat_line_high", {31'd0, uart_tx}, 32'd1);
    @(posedge clk);
    #1;
    chk("lat_line_low", {31'd0, uart_tx}, 32'd0);
    chk("lat_busy", {31'd0, tx_busy}, 32'd1);
    chk("lat_popped", {31'd0, tx_empty}, 32'd1);
    wait_idle(40 * B);
    chk("single_busy_clks", busy_cnt, 10 * B);
    chk("single_line_idle", {31'd0, uart_tx}, 32'd1);

    // 3: three bytes back to back, no gap between frames
    busy_clr = 1'b1;
    @(posedge clk);
    #1;
    busy_clr = 1'b0;
    exp_q.push_back(8'h72);
    exp_q.push_back(8'h72);
    exp_q.push_back(8'h75);
    push_byte(8'h72);
    push_byte(8'h72);
    push_byte(8'h75);
    wait_idle(60 * B);
    chk("b2b_busy_clks", busy_cnt, 30 * B);
    chk("b2b_empty", {31'd0, tx_empty}, 32'd1);

    // 4: six pushes while idle, the sixth hits a full FIFO and is dropped
    busy_clr = 1'b1;
    @(posedge clk);
    #1;
    busy_clr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      push_byte(8'(i));
      if (i == 4) chk("full_before_5th", {31'd0, tx_full}, 32'd0);
    end
    chk("full_after_5th", {31'd0, tx_full}, 32'd1);
    push_byte(8'h06);
    chk("full_after_drop", {31'd0, tx_full}, 32'd1);
    wait_idle(100 * B);
    chk("drop_busy_clks", busy_cnt, 50 * B);
    chk("drop_q_drained", exp_q.size(), 32'd0);

    // 5: one-clock reset in the middle of frame 0x55 with two bytes queued
    push_byte(8'h55);
    push_byte(8'hA1);
    push_byte(8'hA2);
    repeat (4 * B + 3) @(posedge clk);
    #1;
    chk("abort_in_frame", {31'd0, tx_busy}, 32'd1);
    mon_clear = 1'b1;
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("abort_line_high", {31'd0, uart_tx}, 32'd1);
    chk("abort_empty", {31'd0, tx_empty}, 32'd1);
    chk("abort_busy", {31'd0, tx_busy}, 32'd0);
    chk("abort_full", {31'd0, tx_full}, 32'd0);
    busy_clr = 1'b1;
    @(posedge clk);
    #1;
    busy_clr  = 1'b0;
    mon_clear = 1'b0;
    highs = 0;
    for (int i = 0; i < 12 * B; i++) begin
      @(posedge clk);
      #1;
      if (uart_tx === 1'b1) highs++;
    end
    chk("abort_stays_high", highs, 12 * B);
    chk("abort_no_busy", busy_cnt, 32'd0);

    // 6: push coinciding with the STOP->START pop at 3/4 occupancy
    busy_clr = 1'b1;
    full_clr = 1'b1;
    @(posedge clk);
    #1;
    busy_clr = 1'b0;
    full_clr = 1'b0;
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'hC2);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hC4);
    push_byte(8'hC0);
    push_byte(8'hC1);
    push_byte(8'hC2);
    push_byte(8'hC3);
    repeat (10 * B - 3) @(posedge clk);
    #1;
    chk("chain_in_stop", {31'd0, uart_tx}, 32'd1);
    push_byte(8'hC4);
    chk("chain_next_start", {31'd0, uart_tx}, 32'd0);
    chk("chain_not_full", {31'd0, tx_full}, 32'd0);
    chk("chain_not_empty", {31'd0, tx_empty}, 32'd0);
    wait_idle(100 * B);
    chk("chain_busy_clks", busy_cnt, 50 * B);
    chk("chain_full_never", {31'd0, full_seen}, 32'd0);

    repeat (2 * B) @(posedge clk);
    #1;
    chk("sb_leftover", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
